// File: rtl/processor.sv
// Four-stage pipelined MIPS-subset processor (fetch+decode, execute, memory,
// writeback) with a 64-word instruction ROM and a 32-word data memory.
// Optional macro REGFILE_BYPASS_EN: a decode read of the register being
// written back in the same cycle returns the writeback value.
module processor (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] instruction,
    output logic [31:0] counter,
    output logic        e_register_write,
    output logic        e_memory_to_register,
    output logic        e_memory_write,
    output logic [3:0]  e_alu_control,
    output logic        e_alu_immediate,
    output logic [4:0]  e_register_destination,
    output logic [31:0] e_rs_data,
    output logic [31:0] e_rt_data,
    output logic [31:0] e_immediate,
    output logic        m_register_write,
    output logic        m_memory_to_register,
    output logic        m_memory_write,
    output logic [4:0]  m_register_destination,
    output logic [31:0] m_result,
    output logic [31:0] m_rt_data,
    output logic        w_register_write,
    output logic        w_memory_to_register,
    output logic [4:0]  w_register_destination,
    output logic [31:0] w_result_address,
    output logic [31:0] w_result_data
);
    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Program ROM: four loads of data words 0..3 into $2..$5, then zeros
    logic [XLEN-1:0] imem [64] = '{
        0: 32'h8C020000, 1: 32'h8C030004, 2: 32'h8C040008, 3: 32'h8C05000C,
        default: 32'h0
    };
    // Data RAM power-up contents; reset leaves it untouched
    logic [XLEN-1:0] dmem [32] = '{
        0: 32'hA00000AA, 1: 32'h10000011, 2: 32'h20000022, 3: 32'h30000033,
        default: 32'h0
    };
    logic [XLEN-1:0] regs [32];

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic            d_register_write;
    logic            d_memory_to_register;
    logic            d_memory_write;
    logic [3:0]      d_alu_control;
    logic            d_alu_immediate;
    logic [4:0]      d_register_destination;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] dmem_rdata;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;

    assign instruction = imem[counter[7:2]];
    assign op          = instruction[31:26];
    assign rs          = instruction[25:21];
    assign rt          = instruction[20:16];
    assign rd          = instruction[15:11];
    assign funct       = instruction[5:0];
    assign dmem_rdata  = dmem[m_result[6:2]];
    assign wb_data     = w_memory_to_register ? w_result_data : w_result_address;
    assign wb_en       = w_register_write && (w_register_destination != 5'd0);

    // Instruction decode into control bits; unknown encodings decode to all-zero
    always_comb begin
        d_register_write       = 1'b0;
        d_memory_to_register   = 1'b0;
        d_memory_write         = 1'b0;
        d_alu_control          = 4'b0000;
        d_alu_immediate        = 1'b0;
        d_register_destination = 5'd0;
        case (op)
            OP_LW: begin
                d_register_write       = 1'b1;
                d_memory_to_register   = 1'b1;
                d_alu_immediate        = 1'b1;
                d_alu_control          = ALU_ADD;
                d_register_destination = rt;
            end
            OP_SW: begin
                d_memory_write  = 1'b1;
                d_alu_immediate = 1'b1;
                d_alu_control   = ALU_ADD;
            end
            OP_ADDI: begin
                d_register_write       = 1'b1;
                d_alu_immediate        = 1'b1;
                d_alu_control          = ALU_ADD;
                d_register_destination = rt;
            end
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                    funct == FN_OR || funct == FN_SLT) begin
                    d_register_write       = 1'b1;
                    d_register_destination = rd;
                    case (funct)
                        FN_SUB:  d_alu_control = ALU_SUB;
                        FN_AND:  d_alu_control = ALU_AND;
                        FN_OR:   d_alu_control = ALU_OR;
                        FN_SLT:  d_alu_control = ALU_SLT;
                        default: d_alu_control = ALU_ADD;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Register file read ports; $0 is hardwired to zero
    always_comb begin
        rs_data = (rs == 5'd0) ? '0 : regs[rs];
        rt_data = (rt == 5'd0) ? '0 : regs[rt];
`ifdef REGFILE_BYPASS_EN
        if (wb_en && (w_register_destination == rs)) rs_data = wb_data;
        if (wb_en && (w_register_destination == rt)) rt_data = wb_data;
`endif
    end

    // ALU; add/sub wrap, slt compares signed
    always_comb begin
        alu_b = e_alu_immediate ? e_immediate : e_rt_data;
        case (e_alu_control)
            ALU_AND: alu_result = e_rs_data & alu_b;
            ALU_OR:  alu_result = e_rs_data | alu_b;
            ALU_ADD: alu_result = e_rs_data + alu_b;
            ALU_SUB: alu_result = e_rs_data - alu_b;
            ALU_SLT: alu_result = ($signed(e_rs_data) < $signed(alu_b)) ? XLEN'(1) : XLEN'(0);
            default: alu_result = '0;
        endcase
    end

    // PC and pipeline registers; reset flushes every stage
    always_ff @(posedge clock) begin
        if (reset) begin
            counter                <= '0;
            e_register_write       <= 1'b0;
            e_memory_to_register   <= 1'b0;
            e_memory_write         <= 1'b0;
            e_alu_control          <= 4'b0000;
            e_alu_immediate        <= 1'b0;
            e_register_destination <= 5'd0;
            e_rs_data              <= '0;
            e_rt_data              <= '0;
            e_immediate            <= '0;
            m_register_write       <= 1'b0;
            m_memory_to_register   <= 1'b0;
            m_memory_write         <= 1'b0;
            m_register_destination <= 5'd0;
            m_result               <= '0;
            m_rt_data              <= '0;
            w_register_write       <= 1'b0;
            w_memory_to_register   <= 1'b0;
            w_register_destination <= 5'd0;
            w_result_address       <= '0;
            w_result_data          <= '0;
        end else begin
            counter                <= counter + XLEN'(4);
            e_register_write       <= d_register_write;
            e_memory_to_register   <= d_memory_to_register;
            e_memory_write         <= d_memory_write;
            e_alu_control          <= d_alu_control;
            e_alu_immediate        <= d_alu_immediate;
            e_register_destination <= d_register_destination;
            e_rs_data              <= rs_data;
            e_rt_data              <= rt_data;
            e_immediate            <= {{16{instruction[15]}}, instruction[15:0]};
            m_register_write       <= e_register_write;
            m_memory_to_register   <= e_memory_to_register;
            m_memory_write         <= e_memory_write;
            m_register_destination <= e_register_destination;
            m_result               <= alu_result;
            m_rt_data              <= e_rt_data;
            w_register_write       <= m_register_write;
            w_memory_to_register   <= m_memory_to_register;
            w_register_destination <= m_register_destination;
            w_result_address       <= m_result;
            w_result_data          <= dmem_rdata;
        end
    end

    // Register file writeback; reset clears all registers and blocks the write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[w_register_destination] <= wb_data;
        end
    end

    // Data memory store; suppressed on a reset edge
    always_ff @(posedge clock) begin
        if (!reset && m_memory_write) dmem[m_result[6:2]] <= m_rt_data;
    end
endmodule

// File: tb/tb_processor.sv
// Directed bench for processor: default load program, mid-run reset,
// then a patched program exercising add overflow, slt, sw/lw and bypass.
module tb_processor;
    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] counter;
    logic        e_register_write, e_memory_to_register, e_memory_write;
    logic [3:0]  e_alu_control;
    logic        e_alu_immediate;
    logic [4:0]  e_register_destination;
    logic [31:0] e_rs_data, e_rt_data, e_immediate;
    logic        m_register_write, m_memory_to_register, m_memory_write;
    logic [4:0]  m_register_destination;
    logic [31:0] m_result, m_rt_data;
    logic        w_register_write, w_memory_to_register;
    logic [4:0]  w_register_destination;
    logic [31:0] w_result_address, w_result_data;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic [31:0] byp_exp;

    processor dut (
        .clock(clock), .reset(reset), .instruction(instruction), .counter(counter),
        .e_register_write(e_register_write), .e_memory_to_register(e_memory_to_register),
        .e_memory_write(e_memory_write), .e_alu_control(e_alu_control),
        .e_alu_immediate(e_alu_immediate), .e_register_destination(e_register_destination),
        .e_rs_data(e_rs_data), .e_rt_data(e_rt_data), .e_immediate(e_immediate),
        .m_register_write(m_register_write), .m_memory_to_register(m_memory_to_register),
        .m_memory_write(m_memory_write), .m_register_destination(m_register_destination),
        .m_result(m_result), .m_rt_data(m_rt_data),
        .w_register_write(w_register_write), .w_memory_to_register(w_memory_to_register),
        .w_register_destination(w_register_destination),
        .w_result_address(w_result_address), .w_result_data(w_result_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " counter"}, counter, 32'h0);
        check({tag, " instruction"}, instruction, 32'h8C020000);
        check({tag, " e_ctrl"}, {25'd0, e_register_write, e_memory_to_register,
              e_memory_write, e_alu_control, e_alu_immediate}, 32'h0);
        check({tag, " e_dest"}, {27'd0, e_register_destination}, 32'h0);
        check({tag, " e_data"}, e_rs_data | e_rt_data | e_immediate, 32'h0);
        check({tag, " m_ctrl"}, {24'd0, m_register_write, m_memory_to_register,
              m_memory_write, m_register_destination}, 32'h0);
        check({tag, " m_data"}, m_result | m_rt_data, 32'h0);
        check({tag, " w_ctrl"}, {25'd0, w_register_write, w_memory_to_register,
              w_register_destination}, 32'h0);
        check({tag, " w_data"}, w_result_address | w_result_data, 32'h0);
    endtask

    task automatic check_edge1(input string tag);
        check({tag, " counter"}, counter, 32'h4);
        check({tag, " instruction"}, instruction, 32'h8C030004);
        check({tag, " e_dest"}, {27'd0, e_register_destination}, 32'd2);
        check({tag, " e_alu_control"}, {28'd0, e_alu_control}, 32'b0010);
        check({tag, " e_alu_immediate"}, {31'd0, e_alu_immediate}, 32'd1);
        check({tag, " e_memtoreg"}, {31'd0, e_memory_to_register}, 32'd1);
        check({tag, " e_regwrite"}, {31'd0, e_register_write}, 32'd1);
        check({tag, " e_immediate"}, e_immediate, 32'h0);
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'h55;
`else
        byp_exp = 32'h0;
`endif
        // Reset state
        step();
        step();
        check_all_zero("reset");

        // Default program
        reset = 1'b0;
        edge_n = 0;
        step();
        check_edge1("e1");
        step();
        check("e2 m_result", m_result, 32'h0);
        check("e2 m_dest", {27'd0, m_register_destination}, 32'd2);
        check("e2 m_regwrite", {31'd0, m_register_write}, 32'd1);
        check("e2 e_immediate", e_immediate, 32'h4);
        check("e2 e_dest", {27'd0, e_register_destination}, 32'd3);
        step();
        check("e3 w_result_address", w_result_address, 32'h0);
        check("e3 w_result_data", w_result_data, 32'hA00000AA);
        check("e3 w_dest", {27'd0, w_register_destination}, 32'd2);
        check("e3 w_regwrite", {31'd0, w_register_write}, 32'd1);
        run_to(6);
        check("e6 w_result_data", w_result_data, 32'h30000033);
        check("e6 w_dest", {27'd0, w_register_destination}, 32'd5);
        run_to(7);
        check("e7 reg2", dut.regs[2], 32'hA00000AA);
        check("e7 reg3", dut.regs[3], 32'h10000011);
        check("e7 reg4", dut.regs[4], 32'h20000022);
        check("e7 reg5", dut.regs[5], 32'h30000033);
        check("e7 e_ctrl zero", {25'd0, e_register_write, e_memory_to_register,
              e_memory_write, e_alu_control, e_alu_immediate}, 32'h0);
        check("e7 e_dest zero", {27'd0, e_register_destination}, 32'h0);

        // Reset asserted at edge 2 flushes and restarts
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("rr e1 counter", counter, 32'h4);
        reset = 1'b1;
        step();
        check_all_zero("rr");
        check("rr reg2", dut.regs[2], 32'h0);
        reset = 1'b0;
        edge_n = 0;
        step();
        check_edge1("rr e1");
        run_to(3);
        check("rr e3 w_result_data", w_result_data, 32'hA00000AA);
        check("rr e3 w_dest", {27'd0, w_register_destination}, 32'd2);

        // Patched program
        reset = 1'b1;
        for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0;
        dut.imem[0]  = 32'h8C030000; // lw   $3, 0($0)
        dut.imem[1]  = 32'h8C040008; // lw   $4, 8($0)
        dut.imem[2]  = 32'h2001FFFF; // addi $1, $0, -1
        dut.imem[3]  = 32'h20020001; // addi $2, $0, 1
        dut.imem[5]  = 32'h00642822; // sub  $5, $3, $4
        dut.imem[7]  = 32'h0022302A; // slt  $6, $1, $2
        dut.imem[9]  = 32'h20A7FF77; // addi $7, $5, -137
        dut.imem[13] = 32'h00E24020; // add  $8, $7, $2
        dut.imem[17] = 32'hAC080010; // sw   $8, 16($0)
        dut.imem[18] = 32'h8C090010; // lw   $9, 16($0)
        dut.imem[19] = 32'h200A0055; // addi $10, $0, 0x55
        dut.imem[22] = 32'h01405820; // add  $11, $10, $0
        step();
        reset = 1'b0;
        edge_n = 0;
        run_to(7);
        check("sub m_result", m_result, 32'h80000088);
        run_to(8);
        check("slt e_rs_data", e_rs_data, 32'hFFFFFFFF);
        check("slt e_rt_data", e_rt_data, 32'h1);
        check("slt e_alu_control", {28'd0, e_alu_control}, 32'b0111);
        run_to(9);
        check("slt m_result", m_result, 32'h1);
        run_to(11);
        check("addi m_result", m_result, 32'h7FFFFFFF);
        run_to(14);
        check("add e_alu_control", {28'd0, e_alu_control}, 32'b0010);
        run_to(15);
        check("add overflow m_result", m_result, 32'h80000000);
        run_to(18);
        check("sw e_memwrite", {31'd0, e_memory_write}, 32'd1);
        check("sw e_regwrite", {31'd0, e_register_write}, 32'd0);
        run_to(19);
        check("sw m_memwrite", {31'd0, m_memory_write}, 32'd1);
        check("sw m_result", m_result, 32'h10);
        check("sw m_rt_data", m_rt_data, 32'h80000000);
        run_to(21);
        check("lw w_result_data", w_result_data, 32'h80000000);
        check("lw w_result_address", w_result_address, 32'h10);
        check("lw w_dest", {27'd0, w_register_destination}, 32'd9);
        check("lw w_memtoreg", {31'd0, w_memory_to_register}, 32'd1);
        run_to(23);
        check("bypass e_rs_data", e_rs_data, byp_exp);
        check("bypass e_dest", {27'd0, e_register_destination}, 32'd11);
        run_to(24);
        check("bypass m_result", m_result, byp_exp);
        run_to(26);
        check("reg9", dut.regs[9], 32'h80000000);
        check("reg10", dut.regs[10], 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
